// File: rtl/ttt_move_ctrl.sv
// -----------------------------------------------------------------------------
// ttt_move_ctrl
//   N x N tic-tac-toe move controller. Takes 1-based cell positions from the
//   keypad decoder, keeps the X and O occupancy boards, rejects illegal moves,
//   alternates turns, runs a one-cell-per-cycle computer search for O in
//   player-vs-computer mode, and reports win / draw to the display logic.
//
// Parameters
//   N   board side (3..8); a win is N in a row, column or diagonal
//   PW  position width; 2**PW must exceed N*N
//
// Ports
//   i_clk         rising-edge clock
//   i_rst_n       asynchronous active-low reset, clears all state
//   i_start       begin a new game (honoured only in IDLE or DONE)
//   i_pvc         sampled with i_start: 1 = computer plays O
//   i_move_valid  i_position carries a move request this cycle
//   i_position    1-based row-major cell index, 0 = no cell
//   o_x_board     X occupancy, bit i = cell i+1
//   o_o_board     O occupancy, bit i = cell i+1
//   o_illegal     one-cycle pulse after a rejected request
//   o_win         00 in play, 01 X wins, 10 O wins, 11 draw
//   o_turn        0 = X to move, 1 = O to move
//   o_s           state code (IDLE=0 X_WAIT=1 O_WAIT=2 CPU_SCAN=3 CHECK=4 DONE=5)
//
// Handshake: a request is a single cycle with i_move_valid=1; there is no
// ready. Requests are consumed only in X_WAIT / O_WAIT; in every other state
// they are dropped silently.
//
// Build option
//   CPU_CENTER_PREF_EN  when defined and N is odd, the first CPU_SCAN cycle
//                       tries the centre cell before the linear scan from 0.
// -----------------------------------------------------------------------------
module ttt_move_ctrl #(
   parameter int N  = 3,
   parameter int PW = 7
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic             i_pvc,
   input  logic             i_move_valid,
   input  logic [PW-1:0]    i_position,
   output logic [N*N-1:0]   o_x_board,
   output logic [N*N-1:0]   o_o_board,
   output logic             o_illegal,
   output logic [1:0]       o_win,
   output logic             o_turn,
   output logic [2:0]       o_s
);

   localparam int               CELLS    = N * N;
   localparam int               NLINES   = 2 * N + 2;
   localparam logic [CELLS-1:0] ONE      = CELLS'(1);
   localparam logic [PW-1:0]    LAST_POS = PW'(CELLS);

`ifdef CPU_CENTER_PREF_EN
   localparam logic [CELLS-1:0] CENTER_MASK = ONE << ((CELLS - 1) / 2);
   localparam bit               ODD_N       = (N % 2) == 1;
`endif

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      X_WAIT   = 3'd1,
      O_WAIT   = 3'd2,
      CPU_SCAN = 3'd3,
      CHECK    = 3'd4,
      DONE     = 3'd5
   } state_t;

   // Line g: 0..N-1 rows, N..2N-1 columns, 2N main diagonal, 2N+1 anti-diagonal.
   // Anti-diagonal cell k sits at k*N + (N-1-k) = (k+1)*(N-1).
   function automatic logic [CELLS-1:0] line_mask(input int g);
      logic [CELLS-1:0] m;
      m = '0;
      for (int k = 0; k < N; k++) begin
         if (g < N)           m = m | (ONE << (g * N + k));
         else if (g < 2 * N)  m = m | (ONE << ((g - N) + k * N));
         else if (g == 2 * N) m = m | (ONE << (k * (N + 1)));
         else                 m = m | (ONE << ((k + 1) * (N - 1)));
      end
      return m;
   endfunction

   state_t            r_state;
   logic [CELLS-1:0]  r_x;
   logic [CELLS-1:0]  r_o;
   logic              r_illegal;
   logic [1:0]        r_win;
   logic              r_turn;
   logic              r_pvc;
   logic [PW-1:0]     r_idx;
`ifdef CPU_CENTER_PREF_EN
   logic              r_first;
`endif

   logic [CELLS-1:0]  w_occ;
   logic [CELLS-1:0]  w_pos_mask;
   logic [CELLS-1:0]  w_scan_mask;
   logic [CELLS-1:0]  w_mover_board;
   logic [NLINES-1:0] w_line_hit;
   logic              w_pos_in_range;
   logic              w_pos_legal;
   logic              w_mover_wins;
   logic              w_full;

   assign w_occ          = r_x | r_o;
   assign w_pos_in_range = (i_position != '0) && (i_position <= LAST_POS);
   assign w_pos_mask     = w_pos_in_range ? (ONE << (i_position - PW'(1))) : '0;
   assign w_pos_legal    = w_pos_in_range && ((w_occ & w_pos_mask) == '0);
   assign w_scan_mask    = ONE << r_idx;
   // In CHECK, r_turn still names the player who just moved.
   assign w_mover_board  = r_turn ? r_o : r_x;
   assign w_full         = &w_occ;

   for (genvar g = 0; g < NLINES; g++) begin : g_line
      localparam logic [CELLS-1:0] LM = line_mask(g);
      assign w_line_hit[g] = (w_mover_board & LM) == LM;
   end

   assign w_mover_wins = |w_line_hit;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= IDLE;
         r_x       <= '0;
         r_o       <= '0;
         r_illegal <= 1'b0;
         r_win     <= 2'b00;
         r_turn    <= 1'b0;
         r_pvc     <= 1'b0;
         r_idx     <= '0;
`ifdef CPU_CENTER_PREF_EN
         r_first   <= 1'b0;
`endif
      end else begin
         r_illegal <= 1'b0;
         case (r_state)
            IDLE, DONE: begin
               if (i_start) begin
                  r_x     <= '0;
                  r_o     <= '0;
                  r_win   <= 2'b00;
                  r_turn  <= 1'b0;
                  r_pvc   <= i_pvc;
                  r_idx   <= '0;
                  r_state <= X_WAIT;
               end
            end

            X_WAIT, O_WAIT: begin
               if (i_move_valid) begin
                  if (w_pos_legal) begin
                     if (r_state == O_WAIT) r_o <= r_o | w_pos_mask;
                     else                   r_x <= r_x | w_pos_mask;
                     r_state <= CHECK;
                  end else begin
                     r_illegal <= 1'b1;
                  end
               end
            end

            CHECK: begin
               if (w_mover_wins) begin
                  r_win   <= r_turn ? 2'b10 : 2'b01;
                  r_state <= DONE;
               end else if (w_full) begin
                  r_win   <= 2'b11;
                  r_state <= DONE;
               end else begin
                  r_turn <= ~r_turn;
                  if (r_turn) begin
                     r_state <= X_WAIT;
                  end else if (r_pvc) begin
                     // Board is not full here, so the scan always finds a cell.
                     r_idx   <= '0;
`ifdef CPU_CENTER_PREF_EN
                     r_first <= 1'b1;
`endif
                     r_state <= CPU_SCAN;
                  end else begin
                     r_state <= O_WAIT;
                  end
               end
            end

            CPU_SCAN: begin
`ifdef CPU_CENTER_PREF_EN
               r_first <= 1'b0;
               if (r_first && ODD_N) begin
                  // Centre probe costs one cycle; r_idx stays at 0 for the scan.
                  if ((w_occ & CENTER_MASK) == '0) begin
                     r_o     <= r_o | CENTER_MASK;
                     r_state <= CHECK;
                  end
               end else
`endif
               if ((w_occ & w_scan_mask) == '0) begin
                  r_o     <= r_o | w_scan_mask;
                  r_state <= CHECK;
               end else begin
                  r_idx <= r_idx + PW'(1);
               end
            end

            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_x_board = r_x;
   assign o_o_board = r_o;
   assign o_illegal = r_illegal;
   assign o_win     = r_win;
   assign o_turn    = r_turn;
   assign o_s       = r_state;

endmodule

// File: tb/tb_ttt_move_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ttt_move_ctrl
//   Bench for ttt_move_ctrl. Two instances (N=3 and N=4) share all inputs;
//   cur_n selects which one is observed. A cell-array game model predicts
//   legality, boards, winner, next state and the computer's chosen cell and
//   latency. Inputs change and outputs are sampled 1 time unit after posedge.
// -----------------------------------------------------------------------------
module tb_ttt_move_ctrl;

   localparam int PW = 7;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          pvc = 1'b0;
   logic          move_valid = 1'b0;
   logic [PW-1:0] position = '0;

   logic [8:0]  x3, o3;
   logic        ill3, turn3;
   logic [1:0]  win3;
   logic [2:0]  s3;
   logic [15:0] x4, o4;
   logic        ill4, turn4;
   logic [1:0]  win4;
   logic [2:0]  s4;

   always #5 clk = ~clk;

   ttt_move_ctrl #(.N(3), .PW(PW)) dut3 (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_pvc(pvc),
      .i_move_valid(move_valid), .i_position(position),
      .o_x_board(x3), .o_o_board(o3), .o_illegal(ill3), .o_win(win3),
      .o_turn(turn3), .o_s(s3)
   );

   ttt_move_ctrl #(.N(4), .PW(PW)) dut4 (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_pvc(pvc),
      .i_move_valid(move_valid), .i_position(position),
      .o_x_board(x4), .o_o_board(o4), .o_illegal(ill4), .o_win(win4),
      .o_turn(turn4), .o_s(s4)
   );

   int n_chk = 0;
   int n_fail = 0;
   int cur_n = 3;

   logic [63:0] ox, oo;
   logic        o_ill, o_tn;
   logic [1:0]  o_w;
   logic [2:0]  o_st;

   assign ox    = (cur_n == 4) ? {48'd0, x4} : {55'd0, x3};
   assign oo    = (cur_n == 4) ? {48'd0, o4} : {55'd0, o3};
   assign o_ill = (cur_n == 4) ? ill4 : ill3;
   assign o_tn  = (cur_n == 4) ? turn4 : turn3;
   assign o_w   = (cur_n == 4) ? win4 : win3;
   assign o_st  = (cur_n == 4) ? s4 : s3;

   // Model: mb[i] 0 empty, 1 X, 2 O
   int mb[64];
   int m_turn;
   bit m_pvc;
   int m_win;

   function automatic logic [63:0] board_vec(input int v);
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < cur_n * cur_n; i++)
         if (mb[i] == v) r = r | (64'd1 << i);
      return r;
   endfunction

   function automatic bit model_line(input int v);
      int n, st, sp, cnt;
      n = cur_n;
      for (int l = 0; l < 2 * n + 2; l++) begin
         if (l < n)           begin st = l * n; sp = 1;     end
         else if (l < 2 * n)  begin st = l - n; sp = n;     end
         else if (l == 2 * n) begin st = 0;     sp = n + 1; end
         else                 begin st = n - 1; sp = n - 1; end
         cnt = 0;
         for (int k = 0; k < n; k++) if (mb[st + k * sp] == v) cnt++;
         if (cnt == n) return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic bit model_full();
      for (int i = 0; i < cur_n * cur_n; i++) if (mb[i] == 0) return 1'b0;
      return 1'b1;
   endfunction

   function automatic int first_empty();
      for (int i = 0; i < cur_n * cur_n; i++) if (mb[i] == 0) return i;
      return -1;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 64; i++) mb[i] = 0;
      m_turn = 0;
      m_win  = 0;
   endtask

   task automatic hard_reset();
      start = 1'b0; move_valid = 1'b0; position = '0;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic new_game(input bit p);
      start = 1'b1; pvc = p;
      @(posedge clk); #1;
      start = 1'b0;
      model_reset();
      m_pvc = p;
      n_chk++;
      if (o_st !== 3'd1 || ox !== 64'd0 || oo !== 64'd0 || o_w !== 2'b00 || o_tn !== 1'b0) begin
         n_fail++;
         $display("FAIL new_game: s=%0d x=%h o=%h win=%b turn=%b, want s=1 boards 0 win 00 turn 0",
                  o_st, ox, oo, o_w, o_tn);
      end
   endtask

   // One request; follows through CHECK and any computer move until the next wait/done.
   task automatic play(input int pos);
      int cells, mover, w, k, lat, cyc, exp_s;
      bit legal, more;
      cells = cur_n * cur_n;
      legal = 1'b0;
      if (pos >= 1 && pos <= cells) legal = (mb[pos-1] == 0);
      position = PW'(pos); move_valid = 1'b1;
      @(posedge clk); #1;
      move_valid = 1'b0;
      if (!legal) begin
         exp_s = (m_turn == 1) ? 2 : 1;
         n_chk++;
         if (o_ill !== 1'b1 || o_st !== 3'(exp_s) || ox !== board_vec(1) || oo !== board_vec(2)) begin
            n_fail++;
            $display("FAIL illegal_pulse pos=%0d: ill=%b s=%0d x=%h o=%h, want ill=1 s=%0d x=%h o=%h",
                     pos, o_ill, o_st, ox, oo, exp_s, board_vec(1), board_vec(2));
         end
         @(posedge clk); #1;
         n_chk++;
         if (o_ill !== 1'b0 || o_st !== 3'(exp_s)) begin
            n_fail++;
            $display("FAIL illegal_width pos=%0d: ill=%b s=%0d, want ill=0 s=%0d", pos, o_ill, o_st, exp_s);
         end
         return;
      end
      mb[pos-1] = m_turn + 1;
      n_chk++;
      if (ox !== board_vec(1) || oo !== board_vec(2) || o_st !== 3'd4) begin
         n_fail++;
         $display("FAIL accept pos=%0d: x=%h o=%h s=%0d, want x=%h o=%h s=4",
                  pos, ox, oo, o_st, board_vec(1), board_vec(2));
      end
      more = 1'b1;
      while (more) begin
         more = 1'b0;
         @(posedge clk); #1;
         mover = m_turn + 1;
         if (model_line(mover)) w = mover;
         else if (model_full()) w = 3;
         else w = 0;
         if (w != 0) begin
            m_win = w;
            n_chk++;
            if (o_st !== 3'd5 || o_w !== 2'(w)) begin
               n_fail++;
               $display("FAIL game_over: s=%0d win=%b, want s=5 win=%0d", o_st, o_w, w);
            end
         end else begin
            m_turn = m_turn ^ 1;
            if (m_turn == 0) exp_s = 1;
            else if (m_pvc)  exp_s = 3;
            else             exp_s = 2;
            n_chk++;
            if (o_st !== 3'(exp_s) || o_w !== 2'b00 || o_tn !== m_turn[0]) begin
               n_fail++;
               $display("FAIL next_turn: s=%0d win=%b turn=%b, want s=%0d win=00 turn=%0d",
                        o_st, o_w, o_tn, exp_s, m_turn);
            end
            if (exp_s == 3) begin
               k = first_empty();
               lat = k + 1;
`ifdef CPU_CENTER_PREF_EN
               if (cur_n % 2 == 1) begin
                  if (mb[(cells - 1) / 2] == 0) begin
                     k = (cells - 1) / 2;
                     lat = 1;
                  end else begin
                     lat = k + 2;
                  end
               end
`endif
               cyc = 0;
               while (cyc < cells + 3 && oo === board_vec(2)) begin
                  @(posedge clk); #1;
                  cyc++;
               end
               mb[k] = 2;
               n_chk++;
               if (cyc != lat || oo !== board_vec(2) || o_st !== 3'd4) begin
                  n_fail++;
                  $display("FAIL cpu_move: cycles=%0d o=%h s=%0d, want cycles=%0d o=%h s=4",
                           cyc, oo, o_st, lat, board_vec(2));
               end
               more = 1'b1;
            end
         end
      end
   endtask

   task automatic play_ignored(input int pos);
      position = PW'(pos); move_valid = 1'b1;
      @(posedge clk); #1;
      move_valid = 1'b0;
      n_chk++;
      if (o_ill !== 1'b0 || o_st !== 3'd5 || ox !== board_vec(1) || oo !== board_vec(2) || o_w !== 2'(m_win)) begin
         n_fail++;
         $display("FAIL done_ignore pos=%0d: ill=%b s=%0d x=%h o=%h win=%b, want ill=0 s=5 x=%h o=%h win=%0d",
                  pos, o_ill, o_st, ox, oo, o_w, board_vec(1), board_vec(2), m_win);
      end
   endtask

   task automatic finish_game();
      int guard;
      guard = 0;
      while (m_win == 0 && guard < 100) begin
         guard++;
         play(first_empty() + 1);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_chk++;
      if (o_st !== 3'd0 || o_tn !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: s=%0d turn=%b, want 0 0", o_st, o_tn);
      end
      n_chk++;
      if (ox !== 64'd0 || oo !== 64'd0) begin
         n_fail++;
         $display("FAIL reset_boards: x=%h o=%h, want 0 0", ox, oo);
      end
      n_chk++;
      if (o_w !== 2'b00 || o_ill !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_flags: win=%b ill=%b, want 00 0", o_w, o_ill);
      end
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_x_win();
      int seq[5] = '{1, 4, 2, 5, 3};
      cur_n = 3;
      new_game(1'b0);
      foreach (seq[i]) play(seq[i]);
      n_chk++;
      if (ox !== 64'h007 || oo !== 64'h018 || o_w !== 2'b01 || o_st !== 3'd5) begin
         n_fail++;
         $display("FAIL x_win: x=%h o=%h win=%b s=%0d, want x=007 o=018 win=01 s=5", ox, oo, o_w, o_st);
      end
      play_ignored(9);
      play_ignored(0);
   endtask

   task automatic test_illegal();
      cur_n = 3;
      new_game(1'b0);
      play(0);
      play(10);
      play(5);
      play(5);
      play(1);
      play(1);
      // start mid-game must be ignored
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n_chk++;
      if (o_st !== 3'd1 || ox !== board_vec(1) || oo !== board_vec(2)) begin
         n_fail++;
         $display("FAIL start_ignored: s=%0d x=%h o=%h, want s=1 x=%h o=%h",
                  o_st, ox, oo, board_vec(1), board_vec(2));
      end
      finish_game();
   endtask

   task automatic test_cpu();
      logic [63:0] exp_o;
      cur_n = 3;
      new_game(1'b1);
      play(1);
`ifdef CPU_CENTER_PREF_EN
      exp_o = 64'h010;
`else
      exp_o = 64'h002;
`endif
      n_chk++;
      if (oo !== exp_o || ox !== 64'h001) begin
         n_fail++;
         $display("FAIL cpu_first: x=%h o=%h, want x=001 o=%h", ox, oo, exp_o);
      end
      finish_game();
   endtask

   task automatic test_draw();
      int seq[9] = '{1, 2, 3, 5, 4, 6, 8, 7, 9};
      cur_n = 3;
      new_game(1'b0);
      foreach (seq[i]) play(seq[i]);
      n_chk++;
      if (o_w !== 2'b11 || o_st !== 3'd5 || ox !== 64'h18D || oo !== 64'h072) begin
         n_fail++;
         $display("FAIL draw: win=%b s=%0d x=%h o=%h, want win=11 s=5 x=18d o=072", o_w, o_st, ox, oo);
      end
   endtask

   task automatic test_n4_antidiag();
      int seq[7] = '{4, 1, 7, 2, 10, 3, 13};
      cur_n = 4;
      hard_reset();
      new_game(1'b0);
      foreach (seq[i]) play(seq[i]);
      n_chk++;
      if (o_w !== 2'b01 || o_st !== 3'd5 || ox !== 64'h1248) begin
         n_fail++;
         $display("FAIL n4_antidiag: win=%b s=%0d x=%h, want win=01 s=5 x=1248", o_w, o_st, ox);
      end
      hard_reset();
      cur_n = 3;
   endtask

   task automatic test_reset_mid_scan();
      cur_n = 3;
      hard_reset();
      new_game(1'b1);
      position = PW'(1); move_valid = 1'b1;
      @(posedge clk); #1;
      move_valid = 1'b0;
      @(posedge clk); #1;
      n_chk++;
      if (o_st !== 3'd3) begin
         n_fail++;
         $display("FAIL scan_entry: s=%0d, want 3", o_st);
      end
      rst_n = 1'b0;
      #1;
      n_chk++;
      if (o_st !== 3'd0 || ox !== 64'd0 || oo !== 64'd0 || o_w !== 2'b00 || o_tn !== 1'b0 || o_ill !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset: s=%0d x=%h o=%h win=%b turn=%b ill=%b, want all 0",
                  o_st, ox, oo, o_w, o_tn, o_ill);
      end
      #2;
      rst_n = 1'b1;
      model_reset();
      @(posedge clk); #1;
      new_game(1'b0);
      play(5);
      finish_game();
   endtask

   task automatic test_random();
      int cells, pos, guard;
      int e[$];
      for (int g = 0; g < 8; g++) begin
         cur_n = ($urandom_range(0, 1) == 1) ? 4 : 3;
         cells = cur_n * cur_n;
         hard_reset();
         new_game(1'($urandom_range(0, 1)));
         guard = 0;
         while (m_win == 0 && guard < 200) begin
            guard++;
            if ($urandom_range(0, 9) < 7) begin
               e.delete();
               for (int i = 0; i < cells; i++) if (mb[i] == 0) e.push_back(i);
               pos = e[$urandom_range(0, e.size() - 1)] + 1;
            end else begin
               pos = $urandom_range(0, cells + 1);
            end
            play(pos);
         end
         n_chk++;
         if (m_win == 0) begin
            n_fail++;
            $display("FAIL random_game_end: game %0d not finished, want finished", g);
         end
         play_ignored($urandom_range(1, cells));
      end
      hard_reset();
      cur_n = 3;
   endtask

   initial begin
      test_reset();
      test_x_win();
      test_illegal();
      test_cpu();
      test_draw();
      test_n4_antidiag();
      test_reset_mid_scan();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/ttt_move_ctrl.md
# ttt_move_ctrl

Parametrised N×N tic-tac-toe move controller, successor to the fixed 3×3 player-vs-computer FSM. Accepts 1-based cell positions, maintains the X and O occupancy boards, rejects illegal moves, alternates turns, runs a multi-cycle computer move search in player-vs-computer mode, and detects win or draw. Sits between the keypad/position decoder and the display/scoring logic.

## Interface
- N, 3, board side length; legal range 3..8; a win is N in a row.
- PW, 7, position width; must satisfy 2^PW > N*N.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; clears all state
- start  in  1  begin a new game from IDLE or DONE (clears the boards)
- pvc  in  1  sampled on start: 1 = player vs computer (computer plays O), 0 = player vs player
- move_valid  in  1  position is a request this cycle
- position  in  PW  1-based cell index, 1..N*N, row-major; 0 = no cell
- x_board  out  N*N  X occupancy; bit i = cell i+1
- o_board  out  N*N  O occupancy
- illegal  out  1  one-cycle pulse: rejected request
- win  out  2  00 in play, 01 X wins, 10 O wins, 11 draw
- turn  out  1  0 = X to move, 1 = O to move
- S  out  3  state code

## Operation
- States: IDLE=0, X_WAIT=1, O_WAIT=2, CPU_SCAN=3, CHECK=4, DONE=5.
- IDLE: boards zero, win=00. start=1 -> clear boards, latch pvc, go to X_WAIT.
- X_WAIT / O_WAIT: on move_valid=1, legal when 1 <= position <= N*N and cell empty in both boards; legal -> set the bit in the mover's board, go to CHECK. Illegal -> illegal pulses, boards unchanged, state held. move_valid=0 -> hold.
- pvc=1: O_WAIT is never entered; CHECK after an X move goes to CPU_SCAN; move_valid is ignored in CPU_SCAN.
- CPU_SCAN: index register starts at 0, tests one cell per cycle; the first empty cell is claimed into o_board and the FSM goes to CHECK. The scan cannot fail, because CHECK reaches CPU_SCAN only when an empty cell exists.
- CHECK: evaluates the registered boards over N rows, N columns and 2 diagonals.
  - The player who just moved completes a line -> win = 01/10, go to DONE.
  - Otherwise, all N*N cells full -> win=11, go to DONE.
  - Otherwise, toggle turn and go to X_WAIT, O_WAIT or CPU_SCAN.
- DONE: boards and win frozen; requests ignored with no illegal pulse. start -> clear and go to X_WAIT.
- start in any state other than IDLE and DONE is ignored.
- Reset, including mid-scan or mid-game: S=IDLE, boards=0, win=00, turn=0, illegal=0, scan index=0.

## Timing
- Legal human move: board bit visible the cycle after the accepting edge; win valid one cycle later (CHECK); next-turn state one cycle after that.
- Illegal pulse: asserted the cycle after the offending request, for exactly one cycle.
- CPU move latency: first-empty index k (0-based) -> claimed k+1 cycles after entering CPU_SCAN; worst case N*N cycles.
- win changes only on the CHECK->DONE transition or on a clearing start.

## Configuration
- CPU_CENTER_PREF_EN defined:
  - The first CPU_SCAN cycle tests the centre cell (index (N*N-1)/2, odd N only) and claims it if empty.
  - Otherwise the linear scan starts the next cycle at index 0.
  - For even N the macro has no effect.
- Undefined: plain linear scan from index 0.

## Test plan
- N=3, pvc=0: X plays 1, O plays 4, X plays 2, O plays 5, X plays 3 -> x_board=9'h007, win=01, S=DONE. Further requests are ignored.
- N=3: position 0, position 10, and an occupied cell -> illegal high for one cycle each, boards unchanged, S unchanged.
- N=3, pvc=1, macro undefined: X plays 1 -> O claims cell 2 (o_board=9'h002) exactly 2 cycles after CPU_SCAN entry. With the macro defined -> O claims cell 5 (9'h010) in 1 cycle.
- N=3, pvc=0 draw sequence 1,2,3,5,4,6,8,7,9 -> win=11 after the ninth move.
- N=4, pvc=0: X completes anti-diagonal 4,7,10,13 -> win=01.
- Assert reset low during CPU_SCAN -> all outputs return to reset values immediately. start after release -> clean X_WAIT.
